diff_accumulator: RTL and testbench

DIFF_ACCUMULATOR -- requirements
Module: diff_accumulator

---
 rtl/diff_accumulator.sv | 108 ++++++++++
 tb/tb_diff_accumulator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/diff_accumulator.sv
// Accumulates signed 6-bit differences into a saturating 8-bit sum over blocks of
// DEPTH samples, then holds the block report until the consumer takes it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCUM  | accepting samples, in_ready=1, out_valid=0
// ST_REPORT | block complete, report held until out_ready, in_ready=0
module diff_accumulator #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [5:0] in_diff,
    output logic       in_ready,
    input  logic       clear,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_sum,
    output logic [3:0] out_count,
    output logic       sat_flag
);

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_t     state;
    logic [8:0] sum_next;
    logic [7:0] sum_clamped;
    logic       sat_hit;
    logic [3:0] count_inc;

    // Nine bits hold any sum of an 8-bit and a 6-bit signed value without wrap,
    // so the top two bits directly tell positive or negative overflow.
    always_comb begin
        sum_next    = {{3{in_diff[5]}}, in_diff} + {out_sum[7], out_sum};
        sum_clamped = sum_next[7:0];
        sat_hit     = 1'b0;
        if (sum_next[8:7] == 2'b01) begin
            sum_clamped = 8'h7F;
            sat_hit     = 1'b1;
        end else if (sum_next[8:7] == 2'b10) begin
            sum_clamped = 8'h80;
            sat_hit     = 1'b1;
        end
        count_inc = out_count + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= 8'h00;
            out_count <= 4'd0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            state     <= ST_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= 8'h00;
            out_count <= 4'd0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        out_sum   <= sum_clamped;
                        out_count <= count_inc;
                        if (sat_hit) begin
                            sat_flag <= 1'b1;
                        end
                        if (count_inc == DEPTH_L) begin
                            state     <= ST_REPORT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    // in_ready stays low on the handoff edge, so the next block
                    // cannot start in the same cycle the report is taken.
                    if (out_ready) begin
                        state     <= ST_ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_sum   <= 8'h00;
                        out_count <= 4'd0;
                        sat_flag  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_sum   <= 8'h00;
                    out_count <= 4'd0;
                    sat_flag  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diff_accumulator.sv
// Self-checking bench for diff_accumulator: directed scenarios plus random traffic
// compared against an integer-arithmetic block model.
module tb_diff_accumulator;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [5:0] in_diff;
    logic       in_ready;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic [3:0] out_count;
    logic       sat_flag;

    int checks   = 0;
    int failures = 0;

    int m_sum   = 0;
    int m_count = 0;
    bit m_sat   = 0;
    bit m_rep   = 0;

    diff_accumulator #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_diff   (in_diff),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_count (out_count),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_sum   = 0;
        m_count = 0;
        m_sat   = 0;
        m_rep   = 0;
    endtask

    // Block behaviour from the rules: clamp the running integer sum, count
    // samples, and hold the report until the consumer takes it.
    task automatic model_update(input bit v, input int d, input bit clr, input bit ordy);
        int s;
        if (clr) begin
            model_zero();
        end else if (m_rep) begin
            if (ordy) model_zero();
        end else if (v) begin
            s = m_sum + d;
            if (s > 127) begin
                s = 127;
                m_sat = 1;
            end else if (s < -128) begin
                s = -128;
                m_sat = 1;
            end
            m_sum = s;
            m_count++;
            if (m_count == DEPTH) m_rep = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, m_rep});
        chk({tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, !m_rep});
        chk({tag, ".out_sum"},   out_sum,           8'(m_sum));
        chk({tag, ".out_count"}, {4'd0, out_count}, 8'(m_count));
        chk({tag, ".sat_flag"},  {7'd0, sat_flag},  {7'd0, m_sat});
    endtask

    task automatic step(input string tag, input bit v, input int d, input bit clr, input bit ordy);
        in_valid  = v;
        in_diff   = 6'(d);
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        model_update(v, d, clr, ordy);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0);
    endtask

    initial begin
        int seq29 [8] = '{4, 12, 0, -13, -11, 31, 31, 31};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_diff   = 6'd0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Mixed sample sequence, handoff taken immediately
        for (int i = 0; i < 8; i++) step("seq29", 1, seq29[i], 0, 1);
        chk("seq29.sum_const",   out_sum, 8'h55);
        chk("seq29.valid_const", {7'd0, out_valid}, 8'd1);
        step("seq29.handoff", 1, 9, 0, 1);
        chk("seq29.count_after", {4'd0, out_count}, 8'd0);

        // Positive saturation from the fifth sample
        for (int i = 0; i < 8; i++) begin
            step("pos_sat", 1, 31, 0, 0);
            if (i == 4) chk("pos_sat.fifth", out_sum, 8'h7F);
        end
        chk("pos_sat.flag_const", {7'd0, sat_flag}, 8'd1);
        step("pos_sat.handoff", 0, 0, 0, 1);

        // Negative saturation followed by a clean block
        for (int i = 0; i < 8; i++) step("neg_sat", 1, -32, 0, 0);
        chk("neg_sat.sum_const", out_sum, 8'h80);
        step("neg_sat.handoff", 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("ones", 1, 1, 0, 0);
        chk("ones.sum_const", out_sum, 8'h08);
        chk("ones.sat_const", {7'd0, sat_flag}, 8'd0);

        // Backpressure: report held while in_valid keeps asserting
        for (int i = 0; i < 3; i++) step("stall", 1, 5, 0, 0);
        chk("stall.count_const", {4'd0, out_count}, 8'd8);
        step("stall.release", 1, 5, 0, 1);
        step("stall.first_new", 1, 3, 0, 0);
        step("stall.handoff_wait", 0, 0, 0, 0);

        // Clear beats a concurrent sample
        step("clr_pre", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("clr_fill", 1, 5, 0, 0);
        step("clr", 1, 7, 1, 0);
        chk("clr.sum_const", out_sum, 8'h00);
        for (int i = 0; i < 8; i++) step("clr_after", 1, 1, 0, 0);
        chk("clr_after.sum_const", out_sum, 8'h08);
        step("clr_in_report", 1, 4, 1, 0);

        // Asynchronous reset mid-block, between clock edges
        for (int i = 0; i < 4; i++) step("rst_fill", 1, 6, 0, 0);
        reset = 1'b1;
        #2;
        model_zero();
        check_all("rst_async");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step("rst_after", 1, 2, 0, 0);
        chk("rst_after.sum_const", out_sum, 8'h10);
        step("rst_after.handoff", 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit v, clr, ordy;
            int d;
            v    = ($urandom_range(0, 9) < 8);
            d    = int'($urandom_range(0, 63)) - 32;
            clr  = ($urandom_range(0, 39) == 0);
            ordy = $urandom_range(0, 1) == 1;
            step("rand", v, d, clr, ordy);
        end
        idle("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
